change_dispenser: RTL and testbench

//  Back-end executor for the coin-acceptor FSM. Takes one vend/change request (Dispense,

---
 rtl/coin_pkg.sv | 41 ++++
 rtl/change_dispenser_pulse_timer.sv | 27 ++
 rtl/change_dispenser.sv | 204 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Encodings shared by the coin acceptor and the change dispenser.
// Request bits are ordered {D,RN,RD,R2D}; coin bits {Quarter,Dime,Nickel}.
package coin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEND,
    ST_EJECT,
    ST_WAIT_SEEN,
    ST_GAP,
    ST_DONE,
    ST_JAM
  } state_t;

  localparam logic NICKEL = 1'b0;
  localparam logic DIME   = 1'b1;

  localparam int COIN_N = 0;
  localparam int COIN_D = 1;
  localparam int COIN_Q = 2;

  typedef struct packed {
    logic d;
    logic rn;
    logic rd;
    logic r2d;
  } req_t;

  function automatic logic [1:0] dimes_of(req_t r);
    logic [2:0] s;
    s = {2'b00, r.rd} + {1'b0, r.r2d, 1'b0};
    return (s > 3'd3) ? 2'd3 : s[1:0];
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter shared by the pulse, gap and sensor-timeout phases.
// Holds at zero once it gets there.
module pulse_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Executes one vend/change request at a time, pulsing one actuator per step,
// confirming each coin on the drop sensor and tracking tube inventory.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8,
  parameter int INIT_NICKELS   = 20,
  parameter int INIT_DIMES     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic             dispense_i,
  input  logic             ret_nickel_i,
  input  logic             ret_dime_i,
  input  logic             ret_two_dimes_i,
  output logic             req_ready_o,
  input  logic             coin_seen_i,
  input  logic             refill_i,
  output logic             vend_o,
  output logic             eject_nickel_o,
  output logic             eject_dime_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             jam_o,
  output logic             short_o,
  output logic [CNT_W-1:0] nickel_cnt_o,
  output logic [CNT_W-1:0] dime_cnt_o
);

  localparam int TMAX = max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_TOUT  = TW'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic             r_vend_pend;
  logic [1:0]       r_dimes_todo;
  logic             r_nickel_todo;
  logic [CNT_W-1:0] r_nickels;
  logic [CNT_W-1:0] r_dimes;
  logic             r_short;

  req_t             w_req;
  logic             w_accept;
  logic             w_kind;
  logic             w_empty;
  logic             w_more;
  logic             w_seen;
  logic             w_load;
  logic [TW-1:0]    w_load_val;
  logic             w_tzero;

  assign w_req    = '{d: dispense_i, rn: ret_nickel_i,
                      rd: ret_dime_i, r2d: ret_two_dimes_i};
  assign w_accept = req_valid_i && (r_state == ST_IDLE);
  assign w_kind   = (r_dimes_todo != 2'd0) ? DIME : NICKEL;
  assign w_empty  = (w_kind == DIME) ? (r_dimes == '0)
                                     : (r_nickels == '0);
  assign w_more   = r_vend_pend || (r_dimes_todo != 2'd0)
                    || r_nickel_todo;

  // A coin counts in the last pulse cycle or anywhere in the wait window.
  assign w_seen = coin_seen_i &&
                  ((r_state == ST_WAIT_SEEN) ||
                   ((r_state == ST_EJECT) && !w_empty && w_tzero));

  pulse_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_tzero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = T_PULSE;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_req.d) begin
            w_next = ST_VEND;
          end else if (w_req.rn || w_req.rd || w_req.r2d) begin
            w_next = ST_EJECT;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_VEND: begin
        if (w_tzero) begin
          w_next     = ST_GAP;
          w_load     = 1'b1;
          w_load_val = T_GAP;
        end
      end
      ST_EJECT: begin
        if (w_empty || w_seen) begin
          w_next     = ST_GAP;
          w_load     = 1'b1;
          w_load_val = T_GAP;
        end else if (w_tzero) begin
          w_next     = ST_WAIT_SEEN;
          w_load     = 1'b1;
          w_load_val = T_TOUT;
        end
      end
      ST_WAIT_SEEN: begin
        if (w_seen) begin
          w_next     = ST_GAP;
          w_load     = 1'b1;
          w_load_val = T_GAP;
        end else if (w_tzero) begin
          w_next = ST_JAM;
        end
      end
      ST_GAP: begin
        if (w_tzero) begin
          if (w_more) begin
            w_next = r_vend_pend ? ST_VEND : ST_EJECT;
            w_load = 1'b1;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_JAM:  w_next = ST_JAM;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    vend_o         = (r_state == ST_VEND);
    eject_dime_o   = (r_state == ST_EJECT) && !w_empty && (w_kind == DIME);
    eject_nickel_o = (r_state == ST_EJECT) && !w_empty && (w_kind == NICKEL);
    busy_o         = (r_state != ST_IDLE) && (r_state != ST_JAM);
    done_o         = (r_state == ST_DONE);
    jam_o          = (r_state == ST_JAM);
    req_ready_o    = (r_state == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vend_pend   <= 1'b0;
      r_dimes_todo  <= 2'd0;
      r_nickel_todo <= 1'b0;
      r_nickels     <= CNT_W'(INIT_NICKELS);
      r_dimes       <= CNT_W'(INIT_DIMES);
      r_short       <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && refill_i) begin
        r_nickels <= CNT_W'(INIT_NICKELS);
        r_dimes   <= CNT_W'(INIT_DIMES);
        r_short   <= 1'b0;
      end
      if (w_accept) begin
        r_vend_pend   <= w_req.d;
        r_dimes_todo  <= dimes_of(w_req);
        r_nickel_todo <= w_req.rn;
      end
      if ((r_state == ST_VEND) && w_tzero) begin
        r_vend_pend <= 1'b0;
      end
      if ((r_state == ST_EJECT) && w_empty) begin
        r_short <= 1'b1;
        if (w_kind == DIME) r_dimes_todo <= r_dimes_todo - 2'd1;
        else                r_nickel_todo <= 1'b0;
      end
      if (w_seen) begin
        if (w_kind == DIME) begin
          r_dimes_todo <= r_dimes_todo - 2'd1;
          if (r_dimes != '0) r_dimes <= r_dimes - CNT_W'(1);
        end else begin
          r_nickel_todo <= 1'b0;
          if (r_nickels != '0) r_nickels <= r_nickels - CNT_W'(1);
        end
      end
    end
  end

  assign short_o      = r_short;
  assign nickel_cnt_o = r_nickels;
  assign dime_cnt_o   = r_dimes;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and random requests against an inventory/actuation-sequence model
// of the change dispenser.
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int TOUT  = 64;
  localparam int INIT  = 20;
  localparam int LIM   = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_i, dispense_i, ret_nickel_i;
  logic       ret_dime_i, ret_two_dimes_i;
  logic       req_ready_o, coin_seen_i, refill_i;
  logic       vend_o, eject_nickel_o, eject_dime_o;
  logic       busy_o, done_o, jam_o, short_o;
  logic [7:0] nickel_cnt_o, dime_cnt_o;

  int total = 0;
  int bad   = 0;
  int mn, md;
  bit mshort;

  change_dispenser dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .dispense_i      (dispense_i),
    .ret_nickel_i    (ret_nickel_i),
    .ret_dime_i      (ret_dime_i),
    .ret_two_dimes_i (ret_two_dimes_i),
    .req_ready_o     (req_ready_o),
    .coin_seen_i     (coin_seen_i),
    .refill_i        (refill_i),
    .vend_o          (vend_o),
    .eject_nickel_o  (eject_nickel_o),
    .eject_dime_o    (eject_dime_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .jam_o           (jam_o),
    .short_o         (short_o),
    .nickel_cnt_o    (nickel_cnt_o),
    .dime_cnt_o      (dime_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit v, input bit d, input bit rn,
                         input bit rd, input bit r2d, input bit rf);
    req_valid_i     = v;
    dispense_i      = d;
    ret_nickel_i    = rn;
    ret_dime_i      = rd;
    ret_two_dimes_i = r2d;
    refill_i        = rf;
  endtask

  // Model: vend, then each owed dime, then the nickel; an empty tube
  // skips that coin and raises short.
  task automatic run_req(input bit d, input bit rn, input bit rd,
                         input bit r2d, input int dly, input bit stray,
                         input bit rf, output int lat);
    int exp_q[$];
    int got_q[$];
    int nd, prev, cur, hi, lo, cd, dn, ce, cg;
    bit bw, bg, b1h;
    if (rf) begin
      mn = INIT; md = INIT; mshort = 0;
    end
    if (d) exp_q.push_back(1);
    nd = int'(rd) + 2 * int'(r2d);
    for (int i = 0; i < nd; i++) begin
      if (md > 0) begin exp_q.push_back(2); md--; end
      else mshort = 1;
    end
    if (rn) begin
      if (mn > 0) begin exp_q.push_back(3); mn--; end
      else mshort = 1;
    end
    chk("ready_before_req", req_ready_o, 1);
    set_req(1, d, rn, rd, r2d, rf);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    lat = -1; prev = 0; hi = 0; lo = 0; cd = 0; dn = 0;
    bw = 0; bg = 0; b1h = 0;
    for (int t = 1; t <= LIM; t++) begin
      coin_seen_i = 0;
      if (int'(vend_o) + int'(eject_dime_o) + int'(eject_nickel_o) > 1)
        b1h = 1;
      cur = vend_o ? 1 : eject_dime_o ? 2 : eject_nickel_o ? 3 : 0;
      if (cur != 0) begin
        if (prev == 0) begin
          if (got_q.size() > 0 && lo < GAP) bg = 1;
          got_q.push_back(cur);
          hi = 1;
        end else begin
          if (cur != prev) bw = 1;
          hi++;
        end
      end else if (prev != 0) begin
        if (hi != PULSE) bw = 1;
        lo = 1;
        if (prev != 1) cd = dly;
        else if (stray) coin_seen_i = 1;
      end else begin
        lo++;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) coin_seen_i = 1;
      end
      if (done_o) begin
        dn++;
        if (lat < 0) lat = t;
      end
      prev = cur;
      if (lat >= 0 && t > lat) break;
      tick();
    end
    coin_seen_i = 0;
    ce = 0; cg = 0;
    foreach (exp_q[i]) ce = ce * 4 + exp_q[i];
    foreach (got_q[i]) cg = cg * 4 + got_q[i];
    chk("done_seen", lat > 0, 1);
    chk("done_once", dn, 1);
    chk("act_count", got_q.size(), exp_q.size());
    chk("act_order", cg, ce);
    chk("pulse_width", bw, 0);
    chk("gap_len", bg, 0);
    chk("one_hot", b1h, 0);
    chk("nickel_cnt", nickel_cnt_o, mn);
    chk("dime_cnt", dime_cnt_o, md);
    chk("short", short_o, mshort);
    chk("idle_after", busy_o, 0);
  endtask

  initial begin
    int lat, t;
    bit d, rn, rd, r2d, rf;
    rst = 1;
    coin_seen_i = 0;
    set_req(0, 0, 0, 0, 0, 0);
    mn = INIT; md = INIT; mshort = 0;
    repeat (2) tick();
    rst = 0;
    tick();

    chk("rst_ready", req_ready_o, 1);
    chk("rst_drives", {vend_o, eject_dime_o, eject_nickel_o}, 0);
    chk("rst_flags", {busy_o, done_o, jam_o, short_o}, 0);
    chk("rst_nickels", nickel_cnt_o, INIT);
    chk("rst_dimes", dime_cnt_o, INIT);

    run_req(1, 0, 0, 0, 1, 0, 0, lat);
    chk("vend_latency", lat, PULSE + GAP + 1);

    run_req(1, 0, 0, 1, 4, 0, 0, lat);

    // Stray sensor pulses in IDLE, then during the post-vend gap.
    repeat (3) begin
      coin_seen_i = 1; tick();
      coin_seen_i = 0; tick();
    end
    chk("stray_idle_n", nickel_cnt_o, mn);
    chk("stray_idle_d", dime_cnt_o, md);
    run_req(1, 0, 0, 0, 1, 1, 0, lat);

    run_req(0, 0, 0, 0, 1, 0, 0, lat);
    chk("zero_req_latency", lat, 1);

    while (mn > 0) run_req(0, 1, 0, 0, 2, 0, 0, lat);
    run_req(0, 1, 0, 0, 2, 0, 0, lat);
    chk("nickel_empty", nickel_cnt_o, 0);

    refill_i = 1;
    tick();
    refill_i = 0;
    mn = INIT; md = INIT; mshort = 0;
    chk("refill_n", nickel_cnt_o, INIT);
    chk("refill_d", dime_cnt_o, INIT);
    chk("refill_short", short_o, 0);

    for (int k = 0; k < 24; k++) begin
      d   = 1'($urandom_range(0, 1));
      rn  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      r2d = 1'($urandom_range(0, 1));
      rf  = ($urandom_range(0, 7) == 0);
      run_req(d, rn, rd, r2d, int'($urandom_range(1, 12)),
              1'($urandom_range(0, 1)), rf, lat);
    end

    // Reset in the middle of a dime pulse.
    set_req(1, 0, 0, 1, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    t = 0;
    while (!eject_dime_o && t < 20) begin tick(); t++; end
    chk("dime_pulse_start", eject_dime_o, 1);
    tick();
    rst = 1;
    #1;
    chk("rst_async_drop", eject_dime_o, 0);
    chk("rst_async_ready", req_ready_o, 1);
    chk("rst_async_busy", busy_o, 0);
    mn = INIT; md = INIT; mshort = 0;
    tick();
    rst = 0;
    repeat (3) tick();
    chk("rst_discard", {busy_o, eject_dime_o, done_o}, 0);
    chk("rst_cnt_d", dime_cnt_o, INIT);

    // Sensor never answers: jam after the full wait window.
    set_req(1, 0, 0, 1, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    t = 1;
    while (!jam_o && t < 300) begin tick(); t++; end
    chk("jam_tick", t, PULSE + TOUT + 1);
    chk("jam_flags", {jam_o, req_ready_o, busy_o}, 3'b100);
    chk("jam_drives", {vend_o, eject_dime_o, eject_nickel_o}, 0);
    chk("jam_no_dec", dime_cnt_o, md);
    set_req(1, 1, 0, 0, 0, 0);
    repeat (3) begin
      tick();
      if (vend_o) chk("jam_ignores_req", vend_o, 0);
    end
    set_req(0, 0, 0, 0, 0, 0);
    chk("jam_sticky", {jam_o, vend_o, busy_o}, 3'b100);
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("jam_cleared", {jam_o, req_ready_o}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
